clock_reset_sequencer: RTL



---
 rtl/clock_reset_sequencer_pkg.sv | 22 ++
 rtl/clock_reset_sequencer_reset_sync.sv | 26 ++
 rtl/clock_reset_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and constants for the clock/reset sequencing blocks.
package clock_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  localparam int DEFAULT_SYNC_STAGES    = 3;
  localparam int DEFAULT_STRETCH_CYCLES = 16;

  // Ceiling log2, usable in constant expressions for widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
module reset_sync_async_assert
  import clock_reset_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// Stretches a synchronized reset and releases the per-domain resets one at a time.
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
  parameter int NUM_DOMAINS    = 2,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_sw_reset,
  output logic [NUM_DOMAINS-1:0] io_out_reset,
  output logic                   io_ready,
  output logic [1:0]             io_state
);

  localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam int DOM_W   = clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [DOM_W-1:0] DOM_LAST     = DOM_W'(NUM_DOMAINS - 1);

  logic                   rst_sync;
  seq_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [DOM_W-1:0]       dom;
  logic [NUM_DOMAINS-1:0] out_reset;
  logic                   ready;

  reset_sync_async_assert #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clock    (clock),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  // NOTE: every register, outputs included, takes its value in the async reset branch
  // so the domain resets assert the instant the raw reset rises, with no clock needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      cnt       <= '0;
      dom       <= '0;
      out_reset <= '1;
      ready     <= 1'b0;
    end else if (io_sw_reset && state != HOLD) begin
      state     <= STRETCH;
      cnt       <= '0;
      dom       <= '0;
      out_reset <= '1;
      ready     <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!rst_sync) begin
            state <= STRETCH;
            cnt   <= '0;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            out_reset[0] <= 1'b0;
            cnt          <= '0;
            if (NUM_DOMAINS == 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
              dom   <= DOM_W'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            for (int i = 1; i < NUM_DOMAINS; i++) begin
              if (dom == DOM_W'(i)) out_reset[i] <= 1'b0;
            end
            cnt <= '0;
            dom <= dom + 1'b1;
            // Ready rises on the same edge the last domain is released.
            if (dom == DOM_LAST) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_out_reset = out_reset;
  assign io_ready     = ready;
  assign io_state     = state;

endmodule
